// File: rtl/field_splitter.sv
// Serial-to-parallel field unpacker: rebuilds an MSB-first SOF-framed bit stream
// into {a, b, c} and presents the fields on a valid/ready port with a one-word spill.
module field_splitter #(
  parameter int A_W = 1,
  parameter int B_W = 2,
  parameter int C_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ser_valid,
  input  logic           ser_data,
  input  logic           ser_sof,
  output logic           ser_ready,
  output logic           fld_valid,
  input  logic           fld_ready,
  output logic [A_W-1:0] fld_a,
  output logic [B_W-1:0] fld_b,
  output logic [C_W-1:0] fld_c,
  output logic           err_sof
);

  localparam int F  = A_W + B_W + C_W;
  localparam int CW = $clog2(F + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t         state_q, state_d;
  logic [F-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [F-1:0]   word_q, word_d;
  logic           fld_valid_q, fld_valid_d;
  logic           err_q, err_d;

  logic           accept;
  logic           out_free;
  logic [F-1:0]   shift_in;
  logic [F-1:0]   first_bit;

  assign ser_ready = !rst && (state_q != FULL);
  assign accept    = ser_valid && ser_ready;
  // Output register can take a new word if empty or being drained this cycle.
  assign out_free  = !fld_valid_q || fld_ready;
  assign shift_in  = {shift_q[F-2:0], ser_data};
  assign first_bit = {{(F-1){1'b0}}, ser_data};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    err_d       = 1'b0;
    fld_valid_d = fld_valid_q && !fld_ready;
    case (state_q)
      IDLE: begin
        if (accept && ser_sof) begin
          shift_d = first_bit;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (ser_sof) begin
            shift_d = first_bit;
            cnt_d   = CW'(1);
            err_d   = 1'b1;
          end else if (cnt_q == CW'(F - 1)) begin
            shift_d = shift_in;
            cnt_d   = '0;
            if (out_free) begin
              word_d      = shift_in;
              fld_valid_d = 1'b1;
              state_d     = IDLE;
            end else begin
              // Completed word parks in the shift register until the consumer drains.
              state_d = FULL;
            end
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (fld_valid_q && fld_ready) begin
          word_d      = shift_q;
          fld_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      fld_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      fld_valid_q <= fld_valid_d;
      err_q       <= err_d;
    end
  end

  assign fld_valid = fld_valid_q;
  assign err_sof   = err_q;
  assign fld_a     = word_q[F-1 -: A_W];
  assign fld_b     = word_q[B_W+C_W-1 -: B_W];
  assign fld_c     = word_q[C_W-1:0];

endmodule
